// File: rtl/sum_latch_uart_multi.sv
// sum_latch_uart_multi: latches CHANNELS operands via async strobes, reduces them (sum/max) and sends the result over 8N1 UART
module sum_latch_uart_multi #(
  parameter int BITS = 5,
  parameter int CHANNELS = 4,
  parameter int CLK_DIV = 868,
  localparam int RES_W = BITS + $clog2(CHANNELS),
  localparam int NBYTES = (RES_W + 7) / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] save_n,
  input  logic [BITS-1:0]     data_input,
  input  logic                mode,
  input  logic                uart_tx_en,
  output logic [RES_W-1:0]    result,
  output logic                uart_txd,
  output logic                uart_tx_busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int CW = $clog2(CLK_DIV);
  localparam int YW = $clog2(NBYTES + 1);
  logic [CHANNELS-1:0] s1, s2, s3, fall;
  logic [BITS-1:0] regs [CHANNELS];
  logic [RES_W-1:0] red;
  logic [1:0] trig_q;
  logic trig, pending, tick, last_byte, launch;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [YW-1:0] byte_idx;
  logic [8*NBYTES-1:0] shreg;
  assign fall = s3 & ~s2;
  assign trig = trig_q[1];
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign last_byte = byte_idx == YW'(NBYTES - 1);
  assign launch = (trig && state == IDLE) || (state == STOP && tick && last_byte && (pending || trig));
  // two-flop strobe synchroniser plus a delay stage for falling-edge detection; idles high so reset release is quiet
  always_ff @(posedge clk)
    if (reset) {s1, s2, s3} <= '1;
    else {s1, s2, s3} <= {save_n, s1, s2};
  // each channel captures the shared bus on its own detected strobe edge
  always_ff @(posedge clk)
    for (int i = 0; i < CHANNELS; i++)
      if (reset) regs[i] <= '0;
      else if (fall[i]) regs[i] <= data_input;
  // unsigned sum or maximum across all channels, widened so the sum cannot overflow
  always_comb begin
    red = '0;
    for (int i = 0; i < CHANNELS; i++)
      red = mode ? (RES_W'(regs[i]) > red ? RES_W'(regs[i]) : red) : red + RES_W'(regs[i]);
  end
  // registered result plus a two-cycle trigger delay so the snapshot sees the freshly latched value
  always_ff @(posedge clk)
    if (reset) begin
      result <= '0;
      trig_q <= '0;
    end else begin
      result <= red;
      trig_q <= {trig_q[0], |fall & uart_tx_en};
    end
  // transmitter state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state: bits advance on tick, frames chain until the last byte, then restart if a latch is pending
  always_comb
    state_n = launch ? START :
              !tick ? state :
              state == START ? DATA :
              state == DATA ? (bit_idx == 3'd7 ? STOP : DATA) :
              state == STOP ? (last_byte ? IDLE : START) : IDLE;
  // bit timer, shift register snapshot and pending-latch bookkeeping
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      shreg <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (launch) begin
        shreg <= (8*NBYTES)'(result);
        bit_idx <= '0;
        byte_idx <= '0;
      end else if (tick && state == DATA) begin
        shreg <= shreg >> 1;
        bit_idx <= bit_idx + 1'b1;
      end else if (tick && state == STOP) byte_idx <= byte_idx + 1'b1;
      pending <= launch ? 1'b0 : pending | (trig & (state != IDLE));
    end
  // line level and busy decoded from the registered state
  always_comb begin
    uart_txd = state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
    uart_tx_busy = state != IDLE;
  end
endmodule

// File: tb/tb_sum_latch_uart_multi.sv
// tb_sum_latch_uart_multi: randomized scoreboard bench for sum_latch_uart_multi
module tb_sum_latch_uart_multi;
  localparam int B = 5, C = 4, D = 4, RW = B + $clog2(C), NB = (RW + 7) / 8, FR = 10 * D;
  logic clk = 0, reset = 1, mode = 0, en = 0;
  logic [C-1:0] save_n = '1;
  logic [B-1:0] data_input = '0;
  logic [RW-1:0] result;
  logic uart_txd, uart_tx_busy;
  logic [7:0] save8_n = '1, data8 = '0;
  logic [10:0] result8;
  logic txd8, busy8;
  int checks = 0, failures = 0, cyc = 0;
  int m_ch[C] = '{default: 0};
  int m_res = 0, end_at = -1, trig_at = -1, ev_at = -1, ev_data = 0;
  logic [C-1:0] ev_mask = '0;
  bit m_busy = 0, m_pend = 0, ev_en = 0;
  int q0[$], q1[$];
  int mpos[2], mbyte[2];
  bit mact[2];

  sum_latch_uart_multi #(.BITS(B), .CHANNELS(C), .CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .save_n(save_n), .data_input(data_input), .mode(mode),
    .uart_tx_en(en), .result(result), .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy));

  sum_latch_uart_multi #(.BITS(8), .CHANNELS(8), .CLK_DIV(D)) dut8 (
    .clk(clk), .reset(reset), .save_n(save8_n), .data_input(data8), .mode(1'b0),
    .uart_tx_en(1'b1), .result(result8), .uart_txd(txd8), .uart_tx_busy(busy8));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  function automatic int reduce();
    int r = 0;
    foreach (m_ch[i]) r = mode ? (m_ch[i] > r ? m_ch[i] : r) : r + m_ch[i];
    return r;
  endfunction

  task automatic launch(input int v);
    m_busy = 1;
    end_at = cyc + NB * FR;
    for (int b = 0; b < NB; b++) q0.push_back((v >> (8 * b)) & 255);
  endtask

  // model state after each rising edge: result lags registers by one, transmission starts two after the latch
  task automatic step();
    int snap;
    bit trig;
    cyc++;
    if (reset) begin
      m_ch = '{default: 0};
      m_res = 0; m_busy = 0; m_pend = 0; end_at = -1; trig_at = -1; ev_at = -1;
      q0.delete();
      return;
    end
    snap = m_res;
    m_res = reduce();
    if (cyc == ev_at) begin
      for (int i = 0; i < C; i++) if (ev_mask[i]) m_ch[i] = ev_data;
      if (ev_en) trig_at = cyc + 2;
    end
    trig = cyc == trig_at;
    if (m_busy && cyc == end_at) begin
      if (m_pend || trig) begin m_pend = 0; launch(snap); end
      else m_busy = 0;
    end else if (trig) begin
      if (m_busy) m_pend = 1;
      else launch(snap);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); step(); #1; end
  endtask

  task automatic latch(input logic [C-1:0] mask, input int d, input bit e);
    ev_mask = mask; ev_data = d & ((1 << B) - 1); ev_en = e; ev_at = cyc + 3;
    en = e; data_input = B'(d); save_n = ~mask;
    tick(4);
    save_n = '1;
    tick(3);
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    tick(n);
    reset = 0;
    tick(2);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || q0.size() != 0) && n < 3000) begin tick(); n++; end
    chk("idle_timeout", n < 3000, 1);
  endtask

  // frame decoder: samples mid-bit, aborts on reset, pops the scoreboard at each stop bit
  task automatic mon(input int k, input logic rst, input logic tx);
    int j, e;
    if (rst) begin mact[k] = 0; return; end
    if (!mact[k]) begin
      if (tx !== 1'b0) return;
      mact[k] = 1; mpos[k] = 0; mbyte[k] = 0;
    end else mpos[k]++;
    if (mpos[k] % D != D / 2) return;
    j = mpos[k] / D;
    if (j == 0) chk("start_bit", tx, 0);
    else if (j <= 8) mbyte[k] |= int'(tx) << (j - 1);
    else begin
      chk("stop_bit", tx, 1);
      mact[k] = 0;
      if (k == 0) e = q0.size() != 0 ? q0.pop_front() : -1;
      else e = q1.size() != 0 ? q1.pop_front() : -1;
      chk("frame", mbyte[k], e);
    end
  endtask

  always @(negedge clk) if (cyc > 0) begin
    chk("result", result, m_res);
    chk("busy", uart_tx_busy, m_busy);
    if (!m_busy) chk("idle_line", uart_txd, 1);
    mon(0, reset, uart_txd);
    mon(1, reset, txd8);
  end

  initial begin
    int n, cnt;
    tick(3);
    reset = 0;
    tick(3);
    latch(4'b0001, 5, 1);
    wait_idle();
    latch(4'b1111, 31, 1);
    wait_idle();
    mode = 1;
    tick(5);
    chk("max_mode", result, 31);
    mode = 0;
    tick(2);
    do_reset(2);
    latch(4'b0001, 5, 1);
    latch(4'b0010, 7, 1);
    latch(4'b0100, 1, 1);
    wait_idle();
    chk("pending_sum", result, 13);
    do_reset(2);
    latch(4'b0001, 5, 1);
    tick(8);
    reset = 1;
    tick(1);
    chk("rst_busy", uart_tx_busy, 0);
    chk("rst_txd", uart_txd, 1);
    chk("rst_result", result, 0);
    reset = 0;
    tick(60);
    latch(4'b1000, 9, 0);
    tick(50);
    chk("noen_result", result, 9);
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) mode = ~mode;
      latch(C'($urandom_range(1, (1 << C) - 1)), int'($urandom), $urandom_range(0, 3) != 0);
      tick($urandom_range(0, 50));
    end
    wait_idle();
    save8_n = '0;
    data8 = 8'hFF;
    q1.push_back(8'hF8);
    q1.push_back(8'h07);
    tick(4);
    save8_n = '1;
    n = 0;
    while (!busy8 && n < 20) begin tick(); n++; end
    chk("busy8_rise", busy8, 1);
    cnt = 0;
    while (busy8 && cnt < 200) begin tick(); cnt++; end
    chk("busy8_len", cnt, 80);
    chk("result8", result8, 2040);
    tick(10);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_latch_uart_multi.md
Name: sum_latch_uart_multi

Overview:
Parametrised successor to the two-operand sum-latch UART system. It holds CHANNELS operand registers, each loaded from a shared data bus by its own active-low save strobe. Each register is BITS wide. The block continuously computes a selectable reduction (sum or maximum) over all registers and serialises the result over an 8N1 UART transmitter. It sits directly behind the pad wrapper, and its strobes arrive asynchronously from pins.

Parameters:
BITS, 5, operand width per channel
CHANNELS, 4, number of operand registers (>=2)
CLK_DIV, 868, clk cycles per UART bit (>=2)
Derived: RES_W = BITS + clog2(CHANNELS); NBYTES = ceil(RES_W/8)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
save_n  input  CHANNELS  active-low latch strobes, asynchronous, one per channel
data_input  input  BITS  shared operand bus; must be stable while its strobe is synchronised
mode  input  1  0 = sum of all channels, 1 = maximum of all channels (unsigned)
uart_tx_en  input  1  enables transmission on latch events
result  output  RES_W  registered reduction result
uart_txd  output  1  serial output, idle high
uart_tx_busy  output  1  high while any frame of a transmission is in flight

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: all channel registers 0, result 0, uart_txd 1, uart_tx_busy 0, pending 0. Strobe synchroniser flops reset to 1, so no false edge appears on release.
- Strobe synchronisation: each save_n bit passes through a 2-flop synchroniser, then a falling-edge detector.
  - On a detected edge (cycle E), the channel register loads data_input.
  - Latency is the 3rd rising clk after save_n first reads low at the pad.
- Simultaneous strobes: all channels whose edges are detected in the same cycle load together and count as one latch event.
- Result computation:
  - result registers at E+1 and is recomputed every cycle from the channel registers and mode.
  - Sum is zero-extended to RES_W; it never overflows.
  - Max is zero-extended.
  - A mode change alters result on the next cycle but is not a latch event.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - Each bit is held for exactly CLK_DIV cycles.
  - Frame = start bit (0), 8 data bits LSB first, stop bit (1): 10*CLK_DIV cycles.
  - A transmission is NBYTES frames back-to-back, least-significant byte first; unused upper bits are 0.
- Start of transmission:
  - Trigger: latch event with uart_tx_en=1 while IDLE.
  - At E+2, result is snapshotted into the shift register, busy rises and the start bit begins.
  - The snapshot is immune to later latches or mode changes.
- Latch event while busy (and uart_tx_en=1): sets pending; multiple events coalesce into one pending flag.
- End of transmission:
  - If pending, pending clears and a new transmission of the current result starts on the cycle after the last stop bit ends. Busy stays high continuously.
  - Otherwise busy falls on that cycle.
- uart_tx_en=0:
  - Registers and result still update, but no transmission starts and pending is not set.
  - Deasserting uart_tx_en mid-transmission does not abort it; a pending flag already set is still honoured.
- Reset mid-frame: on the next edge uart_txd=1 and busy=0, and the shift state is discarded; no partial frame resumes.

Test Plan:
(BITS=5, CHANNELS=4, CLK_DIV=4, so RES_W=7, NBYTES=1, frame = 40 cycles)
1. Reset held 3 cycles -> result=0, uart_txd=1, uart_tx_busy=0 throughout; no spurious latch on release.
2. Single latch, no overlap -> byte 0x05:
   - Stimulus: data_input=5, pulse save_n[0], uart_tx_en=1, mode=0.
   - Register loads on 3rd edge, result=5 one cycle later, busy rises next cycle.
   - Line shows 0, 1,0,1,0,0,0,0,0, 1, each held 4 cycles; busy high exactly 40 cycles.
3. Simultaneous latch of all four channels with data_input=31 -> one frame 0x7C; then mode=1 -> result=31 with no new frame.
4. Latch during busy -> pending transmission follows back-to-back:
   - Stimulus: ch0=5 starts a frame; during it, latch ch1=7 and then ch2=1.
   - Busy stays high for 80 cycles; the second frame carries 0x0D; only two frames are sent.
5. Reset asserted at cycle 15 of a frame -> next edge uart_txd=1, busy=0, result=0; no further frame.
6. uart_tx_en=0, latch ch3=9 -> result=9, uart_txd stays 1, busy 0. Re-run with BITS=8, CHANNELS=8, all channels=255 -> result=2040, two frames 0xF8 then 0x07.
